// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA definitions: descriptor kinds, opcode/func constants and field positions.
// Used by the instruction encoder/loader and intended for the control decoder as well.
package mips_isa_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned KIND_W = 4;
    localparam int unsigned OP_W   = 6;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned SH_W   = 5;
    localparam int unsigned FUNC_W = 6;
    localparam int unsigned IMM_W  = 16;
    localparam int unsigned TGT_W  = 26;

    localparam int unsigned OP_LSB   = 26;
    localparam int unsigned RS_LSB   = 21;
    localparam int unsigned RT_LSB   = 16;
    localparam int unsigned RD_LSB   = 11;
    localparam int unsigned SH_LSB   = 6;
    localparam int unsigned FUNC_LSB = 0;
    localparam int unsigned IMM_LSB  = 0;
    localparam int unsigned TGT_LSB  = 0;

    typedef enum logic [KIND_W-1:0] {
        K_RALU    = 4'd0,
        K_SHIFT   = 4'd1,
        K_JR      = 4'd2,
        K_ADDI    = 4'd3,
        K_ADDIU   = 4'd4,
        K_ANDI    = 4'd5,
        K_ORI     = 4'd6,
        K_XORI    = 4'd7,
        K_BEQ     = 4'd8,
        K_BNE     = 4'd9,
        K_LW      = 4'd10,
        K_SW      = 4'd11,
        K_J       = 4'd12,
        K_JAL     = 4'd13,
        K_NOP     = 4'd14,
        K_ILLEGAL = 4'd15
    } kind_e;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_ADDIU = 6'b001001;
    localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_XORI  = 6'b001110;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

    localparam logic [FUNC_W-1:0] F_SLL = 6'b000000;
    localparam logic [FUNC_W-1:0] F_SRL = 6'b000010;
    localparam logic [FUNC_W-1:0] F_SRA = 6'b000011;
    localparam logic [FUNC_W-1:0] F_JR  = 6'b001000;

    // I-type word assembly {op, rs, rt, imm}
    function automatic logic [WORD_W-1:0] enc_itype(
        input logic [OP_W-1:0]  op,
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rt,
        input logic [IMM_W-1:0] imm
    );
        logic [WORD_W-1:0] w;
        w = '0;
        w[OP_LSB +: OP_W]   = op;
        w[RS_LSB +: REG_W]  = rs;
        w[RT_LSB +: REG_W]  = rt;
        w[IMM_LSB +: IMM_W] = imm;
        return w;
    endfunction

endpackage

// File: rtl/instr_encoder.sv
// Combinational descriptor -> 32-bit MIPS word encoder; flags illegal kinds and shift funcs.
module instr_encoder
    import mips_isa_pkg::*;
(
    input  logic [KIND_W-1:0] kind_i,
    input  logic [FUNC_W-1:0] func_i,
    input  logic [REG_W-1:0]  rs_i,
    input  logic [REG_W-1:0]  rt_i,
    input  logic [REG_W-1:0]  rd_i,
    input  logic [SH_W-1:0]   shamt_i,
    input  logic [IMM_W-1:0]  imm_i,
    input  logic [TGT_W-1:0]  target_i,
    output logic [WORD_W-1:0] word_o,
    output logic              illegal_o
);

    always_comb begin
        word_o    = '0;
        illegal_o = 1'b0;
        case (kind_e'(kind_i))
            K_RALU: begin
                word_o[OP_LSB +: OP_W]     = OP_RTYPE;
                word_o[RS_LSB +: REG_W]    = rs_i;
                word_o[RT_LSB +: REG_W]    = rt_i;
                word_o[RD_LSB +: REG_W]    = rd_i;
                word_o[FUNC_LSB +: FUNC_W] = func_i;
            end
            K_SHIFT: begin
                if (func_i == F_SLL || func_i == F_SRL || func_i == F_SRA) begin
                    word_o[RT_LSB +: REG_W]    = rt_i;
                    word_o[RD_LSB +: REG_W]    = rd_i;
                    word_o[SH_LSB +: SH_W]     = shamt_i;
                    word_o[FUNC_LSB +: FUNC_W] = func_i;
                end else begin
                    illegal_o = 1'b1;
                end
            end
            K_JR: begin
                word_o[RS_LSB +: REG_W]    = rs_i;
                word_o[FUNC_LSB +: FUNC_W] = F_JR;
            end
            K_ADDI:  word_o = enc_itype(OP_ADDI,  rs_i, rt_i, imm_i);
            K_ADDIU: word_o = enc_itype(OP_ADDIU, rs_i, rt_i, imm_i);
            K_ANDI:  word_o = enc_itype(OP_ANDI,  rs_i, rt_i, imm_i);
            K_ORI:   word_o = enc_itype(OP_ORI,   rs_i, rt_i, imm_i);
            K_XORI:  word_o = enc_itype(OP_XORI,  rs_i, rt_i, imm_i);
            K_BEQ:   word_o = enc_itype(OP_BEQ,   rs_i, rt_i, imm_i);
            K_BNE:   word_o = enc_itype(OP_BNE,   rs_i, rt_i, imm_i);
            K_LW:    word_o = enc_itype(OP_LW,    rs_i, rt_i, imm_i);
            K_SW:    word_o = enc_itype(OP_SW,    rs_i, rt_i, imm_i);
            K_J: begin
                word_o[OP_LSB +: OP_W]   = OP_J;
                word_o[TGT_LSB +: TGT_W] = target_i;
            end
            K_JAL: begin
                word_o[OP_LSB +: OP_W]   = OP_JAL;
                word_o[TGT_LSB +: TGT_W] = target_i;
            end
            K_NOP:     word_o    = '0;
            K_ILLEGAL: illegal_o = 1'b1;
            default:   illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encode_loader.sv
// Streams decoded instruction descriptors, encodes them and writes the words
// sequentially into instruction memory through a single-entry output register.
module instr_encode_loader
    import mips_isa_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 256
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [ADDR_W-1:0]          base_addr,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_last,
    input  logic [KIND_W-1:0]          in_kind,
    input  logic [FUNC_W-1:0]          in_func,
    input  logic [REG_W-1:0]           in_rs,
    input  logic [REG_W-1:0]           in_rt,
    input  logic [REG_W-1:0]           in_rd,
    input  logic [SH_W-1:0]            in_shamt,
    input  logic [IMM_W-1:0]           in_imm,
    input  logic [TGT_W-1:0]           in_target,
    output logic                       imem_we,
    input  logic                       imem_ready,
    output logic [ADDR_W-1:0]          imem_addr,
    output logic [WORD_W-1:0]          imem_wdata,
    output logic                       busy,
    output logic                       done,
    output logic                       err,
    output logic                       ovf,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [CW-1:0]     count_q, count_d;
    logic              err_q, err_d;
    logic              ovf_q, ovf_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;

    logic [WORD_W-1:0] enc_word;
    logic              enc_illegal;
    logic              wr_done;
    logic              accept;
    logic [CW:0]       committed;
    logic              full;

    instr_encoder u_enc (
        .kind_i    (in_kind),
        .func_i    (in_func),
        .rs_i      (in_rs),
        .rt_i      (in_rt),
        .rd_i      (in_rd),
        .shamt_i   (in_shamt),
        .imm_i     (in_imm),
        .target_i  (in_target),
        .word_o    (enc_word),
        .illegal_o (enc_illegal)
    );

    // Output register frees up in the same cycle it drains, so no bubble
    assign in_ready  = (state_q == S_RUN) && (!we_q || imem_ready);
    assign accept    = in_valid && in_ready;
    assign wr_done   = we_q && imem_ready;
    assign committed = {1'b0, count_q} + (CW+1)'(we_q);
    assign full      = committed >= (CW+1)'(DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            count_q <= '0;
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            count_q <= count_d;
            err_q   <= err_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        count_d = count_q;
        err_d   = err_q;
        ovf_d   = ovf_q;

        if (wr_done) begin
            addr_d  = addr_q + ADDR_W'(4);
            count_d = count_q + CW'(1);
            we_d    = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    addr_d  = base_addr & ~ADDR_W'(3);
                    count_d = '0;
                    err_d   = 1'b0;
                    ovf_d   = 1'b0;
                    we_d    = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (accept) begin
                    // Once DEPTH words are written or pending, descriptors are swallowed
                    if (full) begin
                        ovf_d = 1'b1;
                    end else begin
                        wdata_d = enc_word;
                        we_d    = 1'b1;
                        if (enc_illegal) begin
                            err_d = 1'b1;
                        end
                    end
                    if (in_last) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (!we_q || imem_ready) begin
                    state_d = S_FIN;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        done_d = (state_d == S_FIN);
        busy_d = (state_d != S_IDLE);
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign count      = count_q;
    assign err        = err_q;
    assign ovf        = ovf_q;
    assign done       = done_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed self-checking bench for instr_encode_loader (default build and a DEPTH=2 build).
module tb_instr_encode_loader;

    logic        clk;
    logic        rst_n;
    logic        start, start2;
    logic [31:0] base_addr;
    logic        in_valid, in_last;
    logic [3:0]  in_kind;
    logic [5:0]  in_func;
    logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        imem_ready;

    logic        in_ready, imem_we, busy, done, err, ovf;
    logic [31:0] imem_addr, imem_wdata;
    logic [8:0]  count;

    logic        in_ready2, imem_we2, busy2, done2, err2, ovf2;
    logic [31:0] imem_addr2, imem_wdata2;
    logic [1:0]  count2;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int done2_cnt = 0;

    logic [31:0] wq_a[$], wq_d[$], wq2_a[$], wq2_d[$];
    logic [31:0] exp_a[$], exp_d[$];

    instr_encode_loader #(.ADDR_W(32), .DEPTH(256)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
        .in_kind(in_kind), .in_func(in_func), .in_rs(in_rs), .in_rt(in_rt),
        .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm), .in_target(in_target),
        .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .busy(busy), .done(done), .err(err), .ovf(ovf),
        .count(count)
    );

    instr_encode_loader #(.ADDR_W(32), .DEPTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready2), .in_last(in_last),
        .in_kind(in_kind), .in_func(in_func), .in_rs(in_rs), .in_rt(in_rt),
        .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm), .in_target(in_target),
        .imem_we(imem_we2), .imem_ready(imem_ready), .imem_addr(imem_addr2),
        .imem_wdata(imem_wdata2), .busy(busy2), .done(done2), .err(err2), .ovf(ovf2),
        .count(count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record completed writes and done pulses mid-cycle
    always @(negedge clk) begin
        if (imem_we && imem_ready) begin
            wq_a.push_back(imem_addr);
            wq_d.push_back(imem_wdata);
        end
        if (imem_we2 && imem_ready) begin
            wq2_a.push_back(imem_addr2);
            wq2_d.push_back(imem_wdata2);
        end
        if (done)  done_cnt++;
        if (done2) done2_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_start(input bit sel, input logic [31:0] base);
        base_addr = base;
        if (sel) start2 = 1'b1; else start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic set_desc(input logic [3:0] k, input logic [5:0] f, input logic [4:0] rs,
                            input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                            input logic [15:0] imm, input logic [25:0] tgt, input bit last);
        in_kind = k; in_func = f; in_rs = rs; in_rt = rt; in_rd = rd;
        in_shamt = sh; in_imm = imm; in_target = tgt; in_last = last;
        in_valid = 1'b1;
    endtask

    task automatic send(input bit sel, input logic [3:0] k, input logic [5:0] f, input logic [4:0] rs,
                        input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                        input logic [15:0] imm, input logic [25:0] tgt, input bit last);
        int n;
        logic rdy;
        set_desc(k, f, rs, rt, rd, sh, imm, tgt, last);
        n = 0;
        rdy = 1'b0;
        while (!rdy && n < 50) begin
            @(negedge clk);
            rdy = sel ? in_ready2 : in_ready;
            n++;
        end
        if (!rdy) chk("send_timeout", 64'(rdy), 64'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic wait_idle(input bit sel);
        int n;
        n = 0;
        while ((sel ? busy2 : busy) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("idle_timeout", 64'(sel ? busy2 : busy), 64'(0));
        @(posedge clk); #1;
    endtask

    task automatic chk_writes(input string tag, input bit sel);
        int n;
        n = sel ? wq2_a.size() : wq_a.size();
        chk({tag, "_nwrites"}, 64'(n), 64'(exp_a.size()));
        for (int i = 0; i < exp_a.size() && i < n; i++) begin
            chk($sformatf("%s_addr%0d", tag, i), 64'(sel ? wq2_a[i] : wq_a[i]), 64'(exp_a[i]));
            chk($sformatf("%s_data%0d", tag, i), 64'(sel ? wq2_d[i] : wq_d[i]), 64'(exp_d[i]));
        end
        exp_a.delete(); exp_d.delete();
        wq_a.delete(); wq_d.delete(); wq2_a.delete(); wq2_d.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        rst_n = 1'b0; start = 1'b0; start2 = 1'b0; base_addr = '0;
        in_valid = 1'b0; in_last = 1'b0; in_kind = '0; in_func = '0;
        in_rs = '0; in_rt = '0; in_rd = '0; in_shamt = '0; in_imm = '0; in_target = '0;
        imem_ready = 1'b1;
        #23;
        chk("rst_we", 64'(imem_we), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_err_ovf", 64'({err, ovf}), 64'(0));
        chk("rst_addr_data", {imem_addr, imem_wdata}, 64'(0));
        chk("rst_count", 64'(count), 64'(0));
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Valid in IDLE is never accepted
        set_desc(4'd3, 6'd0, 5'd1, 5'd2, 5'd0, 5'd0, 16'h1, 26'd0, 1'b0);
        @(negedge clk);
        chk("idle_in_ready", 64'(in_ready), 64'(0));
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("idle_no_write", 64'(imem_we), 64'(0));

        // Two-word session
        d0 = done_cnt;
        do_start(1'b0, 32'h0040_0000);
        chk("t1_busy", 64'(busy), 64'(1));
        send(1'b0, 4'd3, 6'd0, 5'd0, 5'd8, 5'd0, 5'd0, 16'd5, 26'd0, 1'b0);
        chk("t1_lat_we", 64'(imem_we), 64'(1));
        chk("t1_lat_data", 64'(imem_wdata), 64'h2008_0005);
        send(1'b0, 4'd0, 6'b100000, 5'd8, 5'd9, 5'd10, 5'd0, 16'd0, 26'd0, 1'b1);
        wait_idle(1'b0);
        exp_a = '{32'h0040_0000, 32'h0040_0004};
        exp_d = '{32'h2008_0005, 32'h0109_5020};
        chk_writes("t1", 1'b0);
        chk("t1_count", 64'(count), 64'(2));
        chk("t1_done", 64'(done_cnt - d0), 64'(1));
        chk("t1_err", 64'(err), 64'(0));

        // Four words with a 3-cycle memory stall on the second
        d0 = done_cnt;
        do_start(1'b0, 32'h0000_1001);
        send(1'b0, 4'd10, 6'd0, 5'd29, 5'd9, 5'd0, 5'd0, 16'd4, 26'd0, 1'b0);
        send(1'b0, 4'd1, 6'd0, 5'd0, 5'd9, 5'd8, 5'd2, 16'd0, 26'd0, 1'b0);
        imem_ready = 1'b0;
        set_desc(4'd2, 6'd0, 5'd31, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("t2_stall_we%0d", c), 64'(imem_we), 64'(1));
            chk($sformatf("t2_stall_addr%0d", c), 64'(imem_addr), 64'h0000_1004);
            chk($sformatf("t2_stall_data%0d", c), 64'(imem_wdata), 64'h0009_4080);
            chk($sformatf("t2_stall_rdy%0d", c), 64'(in_ready), 64'(0));
            @(posedge clk); #1;
        end
        imem_ready = 1'b1;
        send(1'b0, 4'd2, 6'd0, 5'd31, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0, 1'b0);
        send(1'b0, 4'd12, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'd0, 26'h010_0000, 1'b1);
        wait_idle(1'b0);
        exp_a = '{32'h0000_1000, 32'h0000_1004, 32'h0000_1008, 32'h0000_100C};
        exp_d = '{32'h8FA9_0004, 32'h0009_4080, 32'h03E0_0008, 32'h0810_0000};
        chk_writes("t2", 1'b0);
        chk("t2_count", 64'(count), 64'(4));
        chk("t2_done", 64'(done_cnt - d0), 64'(1));

        // Illegal shift func and illegal kind write zero and set sticky err
        do_start(1'b0, 32'h0000_0200);
        send(1'b0, 4'd1, 6'b100000, 5'd0, 5'd9, 5'd8, 5'd2, 16'd0, 26'd0, 1'b0);
        send(1'b0, 4'd15, 6'd0, 5'd3, 5'd4, 5'd5, 5'd0, 16'h1234, 26'd0, 1'b1);
        wait_idle(1'b0);
        exp_a = '{32'h0000_0200, 32'h0000_0204};
        exp_d = '{32'h0000_0000, 32'h0000_0000};
        chk_writes("t3", 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("t3_err_sticky", 64'(err), 64'(1));

        // New start clears err; a start during the session is ignored
        do_start(1'b0, 32'h0000_2000);
        chk("t4_err_clr", 64'(err), 64'(0));
        send(1'b0, 4'd14, 6'd0, 5'd7, 5'd7, 5'd7, 5'd7, 16'h7777, 26'd0, 1'b0);
        do_start(1'b0, 32'h0000_3000);
        send(1'b0, 4'd4, 6'd0, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'd0, 1'b1);
        wait_idle(1'b0);
        exp_a = '{32'h0000_2000, 32'h0000_2004};
        exp_d = '{32'h0000_0000, 32'h2422_FFFF};
        chk_writes("t4", 1'b0);

        // DEPTH=2 build: third descriptor dropped
        d0 = done2_cnt;
        do_start(1'b1, 32'h0000_0100);
        send(1'b1, 4'd6, 6'd0, 5'd3, 5'd4, 5'd0, 5'd0, 16'h00FF, 26'd0, 1'b0);
        send(1'b1, 4'd7, 6'd0, 5'd5, 5'd6, 5'd0, 5'd0, 16'h1234, 26'd0, 1'b0);
        chk("t5_ovf_before", 64'(ovf2), 64'(0));
        send(1'b1, 4'd8, 6'd0, 5'd1, 5'd1, 5'd0, 5'd0, 16'h0003, 26'd0, 1'b1);
        chk("t5_ovf_set", 64'(ovf2), 64'(1));
        wait_idle(1'b1);
        exp_a = '{32'h0000_0100, 32'h0000_0104};
        exp_d = '{32'h3464_00FF, 32'h38A6_1234};
        chk_writes("t5", 1'b1);
        chk("t5_count", 64'(count2), 64'(2));
        chk("t5_done", 64'(done2_cnt - d0), 64'(1));
        chk("t5_ovf_sticky", 64'(ovf2), 64'(1));

        // Reset mid-session with a pending write
        do_start(1'b0, 32'h0000_0080);
        send(1'b0, 4'd3, 6'd0, 5'd1, 5'd1, 5'd0, 5'd0, 16'd1, 26'd0, 1'b0);
        send(1'b0, 4'd3, 6'd0, 5'd2, 5'd2, 5'd0, 5'd0, 16'd2, 26'd0, 1'b0);
        imem_ready = 1'b0;
        @(posedge clk); #1;
        chk("t6_pre_we", 64'(imem_we), 64'(1));
        chk("t6_pre_count", 64'(count), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_we", 64'(imem_we), 64'(0));
        chk("t6_rst_busy", 64'(busy), 64'(0));
        chk("t6_rst_count", 64'(count), 64'(0));
        imem_ready = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        wq_a.delete(); wq_d.delete();
        d0 = done_cnt;
        do_start(1'b0, 32'h0000_0040);
        send(1'b0, 4'd9, 6'd0, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFE, 26'd0, 1'b1);
        wait_idle(1'b0);
        exp_a = '{32'h0000_0040};
        exp_d = '{32'h1422_FFFE};
        chk_writes("t6", 1'b0);
        chk("t6_count", 64'(count), 64'(1));
        chk("t6_done", 64'(done_cnt - d0), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
